// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types and constants for the VGA test-pattern generator.
//               Holds the active-area defaults, colour widths, full-scale
//               levels, pattern mode encodings, the colour-bar table and the
//               bouncing-box size/step constants.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;
    localparam int COORD_W      = 11;

    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;

    localparam logic [R_W-1:0] R_FULL = 3'b111;
    localparam logic [G_W-1:0] G_FULL = 3'b111;
    localparam logic [B_W-1:0] B_FULL = 2'b11;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRID  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: '0,     g: '0,     b: '0};
    localparam rgb_t RGB_WHITE = '{r: R_FULL, g: G_FULL, b: B_FULL};
    localparam rgb_t RGB_RED   = '{r: R_FULL, g: '0,     b: '0};

    localparam int BOX_SIZE = 32;
    localparam int BOX_STEP = 2;

    // Colour-bar table: bar 0 at the left edge, bar 7 at the right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: R_FULL, g: G_FULL, b: B_FULL}; // white
            3'd1:    c = '{r: R_FULL, g: G_FULL, b: '0};     // yellow
            3'd2:    c = '{r: '0,     g: G_FULL, b: B_FULL}; // cyan
            3'd3:    c = '{r: '0,     g: G_FULL, b: '0};     // green
            3'd4:    c = '{r: R_FULL, g: '0,     b: B_FULL}; // magenta
            3'd5:    c = '{r: R_FULL, g: '0,     b: '0};     // red
            3'd6:    c = '{r: '0,     g: '0,     b: B_FULL}; // blue
            default: c = RGB_BLACK;                          // black
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_box_mover.sv
`default_nettype none
// ============================================================================
// Module      : vga_box_mover
// Description : Position of the bouncing overlay box. Steps the top-left
//               corner by BOX_STEP on each axis at every frame start,
//               clamping at the active-area edges and reversing direction.
// Ports       : clk, rst         - pixel clock, synchronous active-high reset
//               frame_start      - one-cycle pulse at the vsync falling edge
//               box_x, box_y     - current top-left corner of the box
// Revision    : 1.0 - initial release
// ============================================================================
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    output logic [COORD_W-1:0] box_x,
    output logic [COORD_W-1:0] box_y
);

    localparam logic [COORD_W-1:0] X_MAX = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [COORD_W-1:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [COORD_W-1:0] STEP  = 11'(BOX_STEP);

    logic [COORD_W-1:0] r_box_x;
    logic [COORD_W-1:0] r_box_y;
    logic               r_dir_x;   // 0 = moving +x, 1 = moving -x
    logic               r_dir_y;   // 0 = moving +y, 1 = moving -y

    // A step that would overshoot an edge lands exactly on it and flips
    // direction; the comparisons are arranged to avoid unsigned wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_box_x <= '0;
            r_box_y <= '0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
        end else if (frame_start) begin
            if (!r_dir_x) begin
                if (r_box_x > X_MAX - STEP) begin
                    r_box_x <= X_MAX;
                    r_dir_x <= 1'b1;
                end else begin
                    r_box_x <= r_box_x + STEP;
                end
            end else begin
                if (r_box_x < STEP) begin
                    r_box_x <= '0;
                    r_dir_x <= 1'b0;
                end else begin
                    r_box_x <= r_box_x - STEP;
                end
            end

            if (!r_dir_y) begin
                if (r_box_y > Y_MAX - STEP) begin
                    r_box_y <= Y_MAX;
                    r_dir_y <= 1'b1;
                end else begin
                    r_box_y <= r_box_y + STEP;
                end
            end else begin
                if (r_box_y < STEP) begin
                    r_box_y <= '0;
                    r_dir_y <= 1'b0;
                end else begin
                    r_box_y <= r_box_y - STEP;
                end
            end
        end
    end

    assign box_x = r_box_x;
    assign box_y = r_box_y;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : 800x600 VGA test-pattern generator. Consumes per-pixel timing
//               and produces 3/3/2 RGB colour bars, grid, checkerboard or
//               gradient, with syncs delayed to match the 2-cycle colour path.
//               Optional macro VGA_PAT_BOX_EN adds a bouncing 32x32 red box.
// Ports       : clk, rst                  - pixel clock, sync active-high reset
//               in_hsync, in_vsync        - timing syncs (active-low)
//               in_active, in_x, in_y     - visible flag and pixel coordinates
//               mode_sel                  - pattern, latched at frame start
//               red, green, blue          - colour to the resistor DAC
//               hsync, vsync              - syncs delayed by 2 cycles
//               frame_cnt                 - frames since reset, mod 256
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int BAR_W      = H_ACTIVE_DEF / 8,
    parameter int GRID_LOG2  = 5,
    parameter int CHECK_LOG2 = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_active,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [1:0]         mode_sel,
    output logic [R_W-1:0]     red,
    output logic [G_W-1:0]     green,
    output logic [B_W-1:0]     blue,
    output logic               hsync,
    output logic               vsync,
    output logic [7:0]         frame_cnt
);

    // ------------------------------------------------------------------
    // Frame start detection, mode latch and frame counter
    // ------------------------------------------------------------------
    logic       r_vsync_prev;
    logic       w_frame_start;
    mode_t      r_mode;
    logic [7:0] r_frame_cnt;

    assign w_frame_start = r_vsync_prev & ~in_vsync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_prev <= 1'b1;
            r_mode       <= MODE_BARS;
            r_frame_cnt  <= '0;
        end else begin
            r_vsync_prev <= in_vsync;
            if (w_frame_start) begin
                r_mode      <= mode_t'(mode_sel);
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;

    // ------------------------------------------------------------------
    // Optional bouncing box
    // ------------------------------------------------------------------
`ifdef VGA_PAT_BOX_EN
    logic [COORD_W-1:0] w_box_x;
    logic [COORD_W-1:0] w_box_y;
    logic               w_box_hit;

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_box_mover (
        .clk         (clk),
        .rst         (rst),
        .frame_start (w_frame_start),
        .box_x       (w_box_x),
        .box_y       (w_box_y)
    );

    assign w_box_hit = (in_x >= w_box_x) && (in_x < w_box_x + 11'(BOX_SIZE)) &&
                       (in_y >= w_box_y) && (in_y < w_box_y + 11'(BOX_SIZE));
`endif

    // ------------------------------------------------------------------
    // Stage 1: per-pixel precompute
    // ------------------------------------------------------------------
    logic [2:0] w_bar;
    logic       w_grid;
    logic       w_check;

    // Bar index from a comparator chain against the bar boundaries.
    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (32'(in_x) >= 32'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
    end

    // Grid lines every 2**GRID_LOG2 pixels, plus the right and bottom edges
    // so the outer frame is closed.
    assign w_grid = (in_x[GRID_LOG2-1:0] == '0) ||
                    (in_y[GRID_LOG2-1:0] == '0) ||
                    (in_x == 11'(H_ACTIVE - 1)) ||
                    (in_y == 11'(V_ACTIVE - 1));

    assign w_check = in_x[CHECK_LOG2] ^ in_y[CHECK_LOG2];

    logic       r_s1_active;
    logic       r_s1_hsync;
    logic       r_s1_vsync;
    logic [2:0] r_s1_bar;
    logic       r_s1_grid;
    logic       r_s1_check;
    logic [2:0] r_s1_xh;
    logic [2:0] r_s1_yh;
`ifdef VGA_PAT_BOX_EN
    logic       r_s1_box;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_active <= 1'b0;
            r_s1_hsync  <= 1'b1;
            r_s1_vsync  <= 1'b1;
            r_s1_bar    <= '0;
            r_s1_grid   <= 1'b0;
            r_s1_check  <= 1'b0;
            r_s1_xh     <= '0;
            r_s1_yh     <= '0;
`ifdef VGA_PAT_BOX_EN
            r_s1_box    <= 1'b0;
`endif
        end else begin
            r_s1_active <= in_active;
            r_s1_hsync  <= in_hsync;
            r_s1_vsync  <= in_vsync;
            r_s1_bar    <= w_bar;
            r_s1_grid   <= w_grid;
            r_s1_check  <= w_check;
            r_s1_xh     <= in_x[9:7];
            r_s1_yh     <= in_y[9:7];
`ifdef VGA_PAT_BOX_EN
            r_s1_box    <= w_box_hit;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour select, blanking and overlay
    // ------------------------------------------------------------------
    rgb_t w_pix;
    rgb_t r_pix;
    logic r_hsync;
    logic r_vsync;

    always_comb begin
        w_pix = RGB_BLACK;
        if (r_s1_active) begin
            case (r_mode)
                MODE_BARS:  w_pix = bar_colour(r_s1_bar);
                MODE_GRID:  w_pix = r_s1_grid ? RGB_WHITE : RGB_BLACK;
                MODE_CHECK: w_pix = r_s1_check ? RGB_BLACK : RGB_WHITE;
                MODE_GRAD:  w_pix = '{r: r_s1_xh, g: r_s1_yh, b: r_frame_cnt[7:6]};
                default:    w_pix = RGB_BLACK;
            endcase
`ifdef VGA_PAT_BOX_EN
            if (r_s1_box) begin
                w_pix = RGB_RED;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix   <= RGB_BLACK;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_pix   <= w_pix;
            r_hsync <= r_s1_hsync;
            r_vsync <= r_s1_vsync;
        end
    end

    assign red   = r_pix.r;
    assign green = r_pix.g;
    assign blue  = r_pix.b;
    assign hsync = r_hsync;
    assign vsync = r_vsync;

endmodule
`default_nettype wire

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Downstream consumer of the 800x600@60 Hz (40 MHz pixel clock) timing stage.
- Takes per-pixel timing (syncs, active flag, x/y coordinates) and produces 8-bit RGB (3R/3G/2B) test patterns.
- Outputs syncs delayed to stay aligned with the colour data.
- Drives the board's VGA resistor DAC directly; used for monitor bring-up and timing verification.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- V_ACTIVE, 600, visible lines per frame
- BAR_W, 100, colour-bar width in pixels (H_ACTIVE/8)
- GRID_LOG2, 5, grid pitch = 2**GRID_LOG2 pixels
- CHECK_LOG2, 6, checker square size = 2**CHECK_LOG2 pixels

Ports:
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  synchronous reset, active-high
- in_hsync  in  1  horizontal sync from timing stage, active-low
- in_vsync  in  1  vertical sync from timing stage, active-low
- in_active  in  1  high during visible pixel
- in_x  in  11  pixel column, 0..H_ACTIVE-1 when active
- in_y  in  11  pixel row, 0..V_ACTIVE-1 when active
- mode_sel  in  2  requested pattern, sampled at frame start only
- red  out  3  red level
- green  out  3  green level
- blue  out  2  blue level
- hsync  out  1  in_hsync delayed 2 cycles, active-low
- vsync  out  1  in_vsync delayed 2 cycles, active-low
- frame_cnt  out  8  frames since reset, wraps 255->0

Behaviour:
- Reset values: red/green/blue = 0, hsync = 1, vsync = 1, frame_cnt = 0, latched mode = 0, pipeline active flags = 0.
- Two-stage pipeline, fixed latency 2 cycles on every output (RGB, hsync, vsync). No stalls, no handshake.
  - Stage 1 registers inputs and precomputes bar index, grid hit and checker bit.
  - Stage 2 selects the colour.
- Frame start = in_vsync 1 in the previous cycle and 0 in the current cycle (falling edge; previous-value register resets to 1). On frame start:
  - mode_sel is latched.
  - frame_cnt increments, modulo 256.
- A mode_sel change mid-frame has no effect until the next frame start.
- Blanking: when the stage-2 active flag is 0, RGB = 0 regardless of mode.
- Full scale: R=3'b111, G=3'b111, B=2'b11; "white" = all three at full scale.
- Mode 0, colour bars: bar i = column range [i*BAR_W, (i+1)*BAR_W), selected by comparator chain (no divider).
  - Bars 0..7 in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is either full scale or 0.
- Mode 1, grid: white when any of the following holds, else black:
  - in_x[GRID_LOG2-1:0]==0
  - in_y[GRID_LOG2-1:0]==0
  - in_x==H_ACTIVE-1
  - in_y==V_ACTIVE-1
- Mode 2, checkerboard: white when in_x[CHECK_LOG2]^in_y[CHECK_LOG2]==0, else black.
- Mode 3, gradient: red=in_x[9:7], green=in_y[9:7], blue=frame_cnt[7:6].
- Coordinates with active=0 are don't-care; no range checking.
- Reset asserted mid-frame: outputs take reset values on the next edge, pipeline flushed. After release, hsync/vsync stay 1 until valid data reaches stage 2, i.e. 2 cycles.
- Reset and frame start in the same cycle: reset wins.

Optional Feature:
- Macro VGA_PAT_BOX_EN.
- Defined:
  - A 32x32 solid red box (R=7, G=0, B=0) overlays every mode inside the active area.
  - Top-left position (box_x, box_y) resets to (0,0), direction +x/+y.
  - At each frame start the position steps ±2 on each axis.
  - If the next box_x would exceed H_ACTIVE-32 or go below 0: clamp to the limit and reverse x direction. Same rule for y with V_ACTIVE-32.
  - Box pixels: box_x <= x < box_x+32 and box_y <= y < box_y+32.
  - Overlay is applied in stage 2; latency is unchanged.
- Undefined: no box, no position registers, output identical to base modes.

Decomposition:
- Package vga_pkg:
  - H_ACTIVE / V_ACTIVE defaults
  - colour widths
  - full-scale constants
  - mode encodings: MODE_BARS=0, MODE_GRID=1, MODE_CHECK=2, MODE_GRAD=3
  - 8-entry bar colour table
  - box size and step constants
- Sub-module vga_box_mover:
  - Instantiated only under VGA_PAT_BOX_EN.
  - Inputs clk, rst, frame_start; outputs box_x, box_y.

Test Plan:
- Reset held 5 cycles, then released with in_vsync=1, in_hsync=1 -> RGB=0, hsync=vsync=1, frame_cnt=0 throughout, and for 2 cycles after release.
- Mode 0, active line y=10 -> x=0 gives white 7/7/3, x=99 white, x=100 yellow 7/7/0, x=700 black, 2-cycle latency; active=0 anywhere gives 0/0/0.
- Mode 1 -> x=32 or y=64 gives white; x=33, y=65 gives black; x=799 gives white.
- mode_sel changed 0->2 mid-frame -> bars continue until the in_vsync falling edge, then checkerboard: (0,0) white, (64,0) black.
- 256 simulated vsync falling edges -> frame_cnt wraps to 0.
- Mode 3 with frame_cnt=192 -> blue=3.
- With VGA_PAT_BOX_EN, 400 frames -> box_x sequence 0,2,4,…,768, then decreasing; box_y reverses at 568; pixel (box_x, box_y) is red.
